// File: rtl/rx_pcs_pkg.sv
// Shared definitions for the 10GBASE-R receive PCS blocks: sync header codes,
// self-synchronous scrambler taps and the block-lock state encoding.
package rx_pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // x^58 + x^39 + 1: state bits 38 and 57 feed the output
  localparam int SCR_LEN   = 58;
  localparam int SCR_TAP_A = 38;
  localparam int SCR_TAP_B = 57;

  typedef enum logic [1:0] {
    ST_TEST = 2'd0,
    ST_SLIP = 2'd1,
    ST_WAIT = 2'd2
  } bl_state_e;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/rx_blocklock_descr_32b_descrambler.sv
// 32-bit unrolled self-synchronous descrambler (x^58 + x^39 + 1), LSB first.
// State and output advance only on words with en=1.
module descrambler_32b
  import rx_pcs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [SCR_LEN-1:0]    r_state;
  logic [SCR_LEN-1:0]    w_state_next;
  logic [31:0]           r_dout;
  logic [31:0]           w_dout;
  // Oldest bit at index 0, newest input bit at the top: bit i of the word sits
  // at SCR_LEN+i and its taps are simply fixed offsets below it.
  logic [SCR_LEN+31:0]   w_line;

  assign w_line[SCR_LEN+31:SCR_LEN] = din;

  genvar gi;
  generate
    for (gi = 0; gi < SCR_LEN; gi++) begin : g_line
      assign w_line[gi]       = r_state[SCR_LEN-1-gi];
      assign w_state_next[gi] = w_line[SCR_LEN+31-gi];
    end
    for (gi = 0; gi < 32; gi++) begin : g_out
      assign w_dout[gi] = w_line[SCR_LEN+gi]
                        ^ w_line[SCR_LEN+gi-SCR_TAP_A-1]
                        ^ w_line[SCR_LEN+gi-SCR_TAP_B-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_dout  <= '0;
    end else if (en) begin
      r_state <= w_state_next;
      r_dout  <= w_dout;
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/rx_blocklock_descr_32b.sv
// Block-lock FSM, slip request and descrambled datapath after the 32-bit RX gearbox.
// Optional hi-BER monitor built when RX_HI_BER_MON_EN is defined.
module rx_blocklock_descr_32b
  import rx_pcs_pkg::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32,
  parameter int BER_WINDOW     = 31250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic [1:0]  ctrl,
  input  logic        din_en,
  input  logic        even,
  output logic [31:0] dout,
  output logic [1:0]  dout_ctrl,
  output logic        dout_en,
  output logic        dout_even,
  output logic        block_lock,
  output logic        slip,
  output logic        hi_ber
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX) + 1;
  localparam int INV_W  = $clog2(SH_INVALID_MAX) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

  logic             r_dout_en, r_dout_even;
  logic [1:0]       r_dout_ctrl;

  bl_state_e        r_state, w_state_next;
  logic [CNT_W-1:0] r_sh_cnt, w_sh_cnt_next, w_sh_cnt_inc;
  logic [INV_W-1:0] r_inv_cnt, w_inv_cnt_next, w_inv_cnt_inc;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic             r_lock, w_lock_next;
  logic             w_hdr_evt, w_hdr_bad;

  assign w_hdr_evt     = din_en & even;
  assign w_hdr_bad     = ~sh_is_valid(ctrl);
  assign w_sh_cnt_inc  = r_sh_cnt + 1'b1;
  assign w_inv_cnt_inc = r_inv_cnt + INV_W'(w_hdr_bad);

  descrambler_32b u_descr (
    .clk  (clk),
    .rst  (rst),
    .en   (din_en),
    .din  (din),
    .dout (dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_en   <= 1'b0;
      r_dout_ctrl <= 2'b00;
      r_dout_even <= 1'b0;
    end else begin
      r_dout_en   <= din_en;
      r_dout_ctrl <= ctrl;
      r_dout_even <= even;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_TEST;
      r_sh_cnt   <= '0;
      r_inv_cnt  <= '0;
      r_wait_cnt <= '0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sh_cnt   <= w_sh_cnt_next;
      r_inv_cnt  <= w_inv_cnt_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_lock     <= w_lock_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sh_cnt_next   = r_sh_cnt;
    w_inv_cnt_next  = r_inv_cnt;
    w_wait_cnt_next = r_wait_cnt;
    w_lock_next     = r_lock;
    case (r_state)
      ST_TEST: begin
        if (w_hdr_evt) begin
          w_sh_cnt_next  = w_sh_cnt_inc;
          w_inv_cnt_next = w_inv_cnt_inc;
          if (!r_lock) begin
            if (w_hdr_bad) begin
              w_state_next = ST_SLIP;
            end else if (w_sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              w_lock_next    = 1'b1;
              w_sh_cnt_next  = '0;
              w_inv_cnt_next = '0;
            end
          // Too many bad headers wins even on the last header of the window
          end else if (w_inv_cnt_inc == INV_W'(SH_INVALID_MAX)) begin
            w_lock_next  = 1'b0;
            w_state_next = ST_SLIP;
          end else if (w_sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
            w_sh_cnt_next  = '0;
            w_inv_cnt_next = '0;
          end
        end
      end
      ST_SLIP: begin
        w_sh_cnt_next   = '0;
        w_inv_cnt_next  = '0;
        w_wait_cnt_next = '0;
        w_state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          w_wait_cnt_next = '0;
          w_state_next    = ST_TEST;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_TEST;
    endcase
  end

  assign dout_en    = r_dout_en;
  assign dout_ctrl  = r_dout_ctrl;
  assign dout_even  = r_dout_even;
  assign block_lock = r_lock;
  // Gated with rst so a reset landing on the SLIP cycle never leaks a pulse
  assign slip       = (r_state == ST_SLIP) & ~rst;

`ifdef RX_HI_BER_MON_EN
  localparam int WIN_W   = $clog2(BER_WINDOW + 1);
  localparam int BER_SAT = 16;

  logic [WIN_W-1:0] r_win_cnt;
  logic [4:0]       r_ber_cnt, w_ber_cnt_next;
  logic             r_hi_ber;

  always_comb begin
    w_ber_cnt_next = r_ber_cnt;
    if (w_hdr_evt && w_hdr_bad && (r_ber_cnt < 5'(BER_SAT)))
      w_ber_cnt_next = r_ber_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= 1'b0;
    end else if (r_win_cnt == WIN_W'(BER_WINDOW - 1)) begin
      r_win_cnt <= '0;
      r_ber_cnt <= '0;
      r_hi_ber  <= (w_ber_cnt_next >= 5'(BER_SAT));
    end else begin
      r_win_cnt <= r_win_cnt + 1'b1;
      r_ber_cnt <= w_ber_cnt_next;
    end
  end

  assign hi_ber = r_hi_ber & r_lock;
`else
  // No monitor: the window length only selects which tie-off block exists.
  if (BER_WINDOW > 0) begin : g_no_ber
    assign hi_ber = 1'b0;
  end else begin : g_no_ber_zero
    assign hi_ber = 1'b0;
  end
`endif

endmodule

// File: tb/tb_rx_blocklock_descr_32b.sv
// Randomized self-checking bench for rx_blocklock_descr_32b against a
// bit-stream / header-window reference model.
module tb_rx_blocklock_descr_32b;

`ifdef RX_HI_BER_MON_EN
  localparam int BER_W = 100;
`else
  localparam int BER_W = 31250;
`endif
  localparam int SH_MAX  = 64;
  localparam int INV_MAX = 16;
  localparam int WAIT_N  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic [1:0]  ctrl = '0;
  logic        din_en = 1'b0;
  logic        even = 1'b0;
  logic [31:0] dout;
  logic [1:0]  dout_ctrl;
  logic        dout_en, dout_even, block_lock, slip, hi_ber;

  always #5 clk = ~clk;

  rx_blocklock_descr_32b #(.BER_WINDOW(BER_W)) dut (
    .clk(clk), .rst(rst), .din(din), .ctrl(ctrl), .din_en(din_en), .even(even),
    .dout(dout), .dout_ctrl(dout_ctrl), .dout_en(dout_en), .dout_even(dout_even),
    .block_lock(block_lock), .slip(slip), .hi_ber(hi_ber)
  );

  int n_total = 0;
  int n_bad   = 0;
  int slips   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint      n_edge = 0;
  longint      blind_until = -1;
  longint      slip_edge = -100;
  bit          m_lock;
  int          m_hdrs, m_bads;
  bit          hist[$];
  logic [31:0] m_dout;
  logic        m_en_d, m_even_d;
  logic [1:0]  m_ctrl_d;
  int          m_win, m_ber;
  bit          m_hi;

  function automatic bit hbit(int k);
    if (hist.size() < k) return 1'b0;
    return hist[hist.size() - k];
  endfunction

  task automatic model_step();
    bit hdr, bad, b;
    n_edge++;
    if (rst) begin
      m_lock = 0; m_hdrs = 0; m_bads = 0; hist.delete(); m_dout = '0;
      m_en_d = 0; m_even_d = 0; m_ctrl_d = '0; blind_until = -1; slip_edge = -100;
      m_win = 0; m_ber = 0; m_hi = 0;
      return;
    end
    m_en_d = din_en; m_even_d = even; m_ctrl_d = ctrl;
    if (din_en) begin
      for (int i = 0; i < 32; i++) begin
        b = din[i];
        m_dout[i] = b ^ hbit(39) ^ hbit(58);
        hist.push_back(b);
        if (hist.size() > 64) void'(hist.pop_front());
      end
    end
    hdr = din_en && even;
    bad = !(ctrl == 2'b01 || ctrl == 2'b10);
    if (hdr && n_edge > blind_until) begin
      m_hdrs++;
      if (bad) m_bads++;
      if ((!m_lock && bad) || (m_lock && m_bads >= INV_MAX)) begin
        m_lock = 0; m_hdrs = 0; m_bads = 0;
        slip_edge = n_edge;
        blind_until = n_edge + 1 + WAIT_N;
      end else if (m_hdrs >= SH_MAX) begin
        m_lock = 1; m_hdrs = 0; m_bads = 0;
      end
    end
    m_win++;
    if (hdr && bad && m_ber < 16) m_ber++;
    if (m_win == BER_W) begin
      m_hi = (m_ber >= 16); m_ber = 0; m_win = 0;
    end
  endtask

  task automatic compare();
    chk("block_lock", block_lock, m_lock);
    chk("slip", slip, (slip_edge == n_edge));
    chk("dout_en", dout_en, m_en_d);
    chk("dout_even", dout_even, m_even_d);
    chk("dout_ctrl", dout_ctrl, m_ctrl_d);
    chk("dout", dout, m_dout);
`ifdef RX_HI_BER_MON_EN
    chk("hi_ber", hi_ber, m_hi & m_lock);
`else
    chk("hi_ber", hi_ber, 1'b0);
`endif
    if (slip === 1'b1) slips++;
  endtask

  // ---------------- stimulus ----------------
  int gb_pos = 0;
  bit gb_even = 1;
  bit bad_mask[64];
  bit sc[$];

  task automatic step(input logic r, input logic en, input logic ev,
                      input logic [1:0] c, input logic [31:0] d);
    rst = r; din_en = en; even = ev; ctrl = c; din = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic gb_word(input logic [1:0] c, input logic [31:0] d);
    if (gb_pos == 32) begin
      step(1'b0, 1'b0, 1'($urandom), 2'($urandom), $urandom);
      gb_pos = 0;
    end
    step(1'b0, 1'b1, gb_even, c, d);
    gb_even = !gb_even;
    gb_pos++;
  endtask

  task automatic gb_block(input logic [1:0] c, input logic [31:0] d0, input logic [31:0] d1);
    gb_word(c, d0);
    gb_word(2'($urandom), d1);
  endtask

  task automatic do_reset(input int k);
    repeat (k) step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), $urandom);
    gb_pos = 0; gb_even = 1; slips = 0;
  endtask

  function automatic logic [1:0] good_sh(int i);
    return (i % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic make_mask(input int k);
    int perm[64];
    int j, t;
    for (int i = 0; i < 64; i++) begin perm[i] = i; bad_mask[i] = 0; end
    for (int i = 63; i > 0; i--) begin
      j = $urandom_range(i, 0); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < k; i++) bad_mask[perm[i]] = 1;
  endtask

  task automatic window(input int k);
    make_mask(k);
    for (int i = 0; i < 64; i++)
      gb_block(bad_mask[i] ? 2'b11 : good_sh(i), $urandom, $urandom);
  endtask

  function automatic logic [31:0] scramble(input logic [31:0] p);
    logic [31:0] s;
    bit b;
    for (int i = 0; i < 32; i++) begin
      b = p[i] ^ sc[sc.size() - 39] ^ sc[sc.size() - 58];
      s[i] = b;
      sc.push_back(b);
      void'(sc.pop_front());
    end
    return s;
  endfunction

  initial begin
    int rate;
    logic [1:0] c;
    logic [31:0] plain;

    // reset state
    do_reset(3);
    chk("rst_lock", block_lock, 1'b0);
    chk("rst_dout", dout, 32'h0);
    $display("phase reset done lock=%0b", block_lock);

    // lock acquisition
    for (int i = 0; i < 63; i++) gb_block(good_sh(i), $urandom, $urandom);
    chk("acq_not_yet", block_lock, 1'b0);
    gb_word(good_sh(63), $urandom);
    chk("acq_lock", block_lock, 1'b1);
    gb_word(2'($urandom), $urandom);
    chk("acq_slips", slips, 0);
    $display("phase acquire done lock=%0b slips=%0d", block_lock, slips);

    // unlocked slip on the 5th header, then reacquire
    do_reset(2);
    for (int i = 0; i < 4; i++) gb_block(good_sh(i), $urandom, $urandom);
    gb_block(2'b00, $urandom, $urandom);
    for (int i = 0; i < 20; i++) gb_block(good_sh(i), $urandom, $urandom);
    chk("uslip_count", slips, 1);
    chk("uslip_unlocked", block_lock, 1'b0);
    for (int i = 0; i < 64; i++) gb_block(good_sh(i), $urandom, $urandom);
    chk("uslip_relock", block_lock, 1'b1);
    $display("phase unlocked-slip done lock=%0b slips=%0d", block_lock, slips);

    // lock loss: two 15-bad windows hold, one 16-bad window drops
    do_reset(2);
    window(0);
    chk("loss_locked", block_lock, 1'b1);
    window(15);
    window(15);
    chk("loss_hold15", block_lock, 1'b1);
    chk("loss_hold_slips", slips, 0);
    window(16);
    chk("loss_drop16", block_lock, 1'b0);
    chk("loss_slips", slips, 1);
    $display("phase lock-loss done lock=%0b slips=%0d", block_lock, slips);

    // descrambler on scrambled idle blocks, random scrambler seed
    do_reset(2);
    sc.delete();
    repeat (58) sc.push_back(1'($urandom));
    for (int w = 0; w < 80; w++) begin
      plain = (w % 2 == 0) ? 32'h0000001E : 32'h0;
      gb_word((w % 2 == 0) ? 2'b10 : 2'($urandom), scramble(plain));
      if (w >= 2) chk("descr_plain", dout, plain);
    end
    $display("phase descrambler done lock=%0b", block_lock);

    // reset in the middle of WAIT
    do_reset(2);
    gb_block(2'b01, $urandom, $urandom);
    gb_block(2'b00, $urandom, $urandom);
    repeat (8) gb_word(2'b01, $urandom);
    step(1'b1, 1'b1, 1'b1, 2'b00, $urandom);
    chk("rstw_slip", slip, 1'b0);
    chk("rstw_en", dout_en, 1'b0);
    chk("rstw_ctrl", dout_ctrl, 2'b00);
    chk("rstw_dout", dout, 32'h0);
    gb_pos = 0; gb_even = 1; slips = 0;
    for (int i = 0; i < 64; i++) gb_block(good_sh(i), $urandom, $urandom);
    chk("rstw_relock", block_lock, 1'b1);
    chk("rstw_slips", slips, 0);
    $display("phase reset-in-wait done lock=%0b slips=%0d", block_lock, slips);

    // randomized traffic with varying error rates and occasional reset
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 4)
        0: rate = 0;
        1: rate = 3;
        2: rate = 22;
        default: rate = 10;
      endcase
      for (int i = 0; i < 80; i++) begin
        c = ($urandom_range(99, 0) < rate) ? 2'($urandom) : good_sh(i);
        gb_block(c, $urandom, $urandom);
        if ($urandom_range(599, 0) == 0) do_reset(1);
      end
      $display("phase random seg=%0d rate=%0d lock=%0b", seg, rate, block_lock);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
